// File: rtl/chan_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chan_fifo_ctrl
// Brief    : Valid/ready channel FIFO controller over an external dual-port RAM
//            with a 2-entry output skid buffer. Define CHAN_FIFO_AFULL_EN to
//            add the registered s_afull flag.
// Revision : 1.0
// ============================================================================
module chan_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
`ifdef CHAN_FIFO_AFULL_EN
    ,
    parameter int AF_MARGIN  = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_a_we,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    output logic [DATA_WIDTH-1:0] ram_a_din,
    output logic                  ram_b_we,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    input  logic [DATA_WIDTH-1:0] ram_b_dout
`ifdef CHAN_FIFO_AFULL_EN
    ,
    output logic                  s_afull
`endif
);

    localparam logic [ADDR_WIDTH:0] c_RD = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_rd_inflight;
    logic [1:0]            r_sk_cnt;
    logic [DATA_WIDTH-1:0] r_sk0;
    logic [DATA_WIDTH-1:0] r_sk1;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_sk_occ;
    logic [1:0]            w_sk_base;

    assign s_ready    = (r_ram_cnt != c_RD);
    assign m_valid    = (r_sk_cnt != 2'd0);
    assign m_data     = r_sk0;
    assign w_push     = s_valid && s_ready;
    assign w_pop      = m_valid && m_ready;

    assign ram_a_we   = w_push;
    assign ram_a_addr = r_wr_ptr;
    assign ram_a_din  = s_data;
    assign ram_b_we   = 1'b0;
    assign ram_b_addr = r_rd_ptr;

    // Skid slots already claimed (held or in flight) once this cycle's pop leaves.
    assign w_sk_occ   = r_sk_cnt + {1'b0, r_rd_inflight} - {1'b0, w_pop};
    assign w_issue    = (r_ram_cnt != '0) && (w_sk_occ < 2'd2);
    assign w_sk_base  = r_sk_cnt - {1'b0, w_pop};

    assign count = {1'b0, r_ram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, r_rd_inflight}
                 + {{ADDR_WIDTH{1'b0}}, r_sk_cnt};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_cnt     <= '0;
            r_rd_inflight <= 1'b0;
            r_sk_cnt      <= 2'd0;
            r_sk0         <= '0;
            r_sk1         <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_cnt     <= r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_push}
                                       - {{ADDR_WIDTH{1'b0}}, w_issue};
            r_rd_inflight <= w_issue;
            r_sk_cnt      <= w_sk_base + {1'b0, r_rd_inflight};
            if (w_pop) begin
                r_sk0 <= r_sk1;
            end
            // The capture lands after the shift, so it overrides entry 0 when the skid empties.
            if (r_rd_inflight) begin
                if (w_sk_base == 2'd0) begin
                    r_sk0 <= ram_b_dout;
                end else begin
                    r_sk1 <= ram_b_dout;
                end
            end
        end
    end

`ifdef CHAN_FIFO_AFULL_EN
    localparam logic [ADDR_WIDTH+1:0] c_AF_LEVEL =
        (ADDR_WIDTH+2)'((1 << ADDR_WIDTH) + 2 - AF_MARGIN);

    logic [ADDR_WIDTH+1:0] w_count_nxt;
    logic                  r_afull;

    // Issue and capture only move beats between stages; only push/pop change the total.
    assign w_count_nxt = count + {{(ADDR_WIDTH+1){1'b0}}, w_push}
                               - {{(ADDR_WIDTH+1){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_count_nxt >= c_AF_LEVEL);
        end
    end

    assign s_afull = r_afull;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chan_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_fifo_ctrl
// Brief    : Scoreboard bench for chan_fifo_ctrl with a behavioural DP RAM.
// Revision : 1.0
// ============================================================================
module tb_chan_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [4:0] count;
    logic       ram_a_we;
    logic [2:0] ram_a_addr;
    logic [7:0] ram_a_din;
    logic       ram_b_we;
    logic [2:0] ram_b_addr;
    logic [7:0] ram_b_dout;
`ifdef CHAN_FIFO_AFULL_EN
    logic       s_afull;
`endif

    chan_fifo_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .ram_a_we   (ram_a_we),
        .ram_a_addr (ram_a_addr),
        .ram_a_din  (ram_a_din),
        .ram_b_we   (ram_b_we),
        .ram_b_addr (ram_b_addr),
        .ram_b_dout (ram_b_dout)
`ifdef CHAN_FIFO_AFULL_EN
        ,
        .s_afull    (s_afull)
`endif
    );

    always #5 clk = ~clk;

    // Dual-port RAM: write on A, registered read on B, old data on collision.
    logic [7:0] mem [8];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            ram_b_dout <= 8'h00;
        end else begin
            if (ram_a_we) mem[ram_a_addr] <= ram_a_din;
            ram_b_dout <= mem[ram_b_addr];
        end
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic       acc, popd, mv, mr, we_bad;
    logic [7:0] pdata;

    // Sample the handshake at the falling edge, then advance past the next rising edge.
    task automatic tick();
        @(negedge clk);
        acc    = s_valid && s_ready;
        popd   = m_valid && m_ready;
        pdata  = m_data;
        mv     = m_valid;
        mr     = m_ready;
        we_bad = ram_a_we && !s_ready;
        if (acc) q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", s_ready); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %02h expected 00", m_data); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (ram_a_we !== 1'b0) $display("FAIL reset_a_we: got %b expected 0", ram_a_we); else n_pass++;
        n_checks++; if (ram_b_we !== 1'b0) $display("FAIL reset_b_we: got %b expected 0", ram_b_we); else n_pass++;
        n_checks++; if (ram_a_addr !== 3'd0 || ram_b_addr !== 3'd0)
            $display("FAIL reset_addr: got a=%0d b=%0d expected 0 0", ram_a_addr, ram_b_addr); else n_pass++;
    endtask

    task automatic test_single_beat();
        do_reset();
        s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
        #1;
        n_checks++; if (ram_a_we !== 1'b1 || ram_a_addr !== 3'd0 || ram_a_din !== 8'h5A)
            $display("FAIL single_write: got we=%b addr=%0d din=%02h expected 1 0 5a", ram_a_we, ram_a_addr, ram_a_din); else n_pass++;
        tick();
        s_valid = 1'b0;
        n_checks++; if (count !== 5'd1 || m_valid !== 1'b0)
            $display("FAIL single_e0: got count=%0d m_valid=%b expected 1 0", count, m_valid); else n_pass++;
        tick();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL single_e1: got m_valid=%b expected 0", m_valid); else n_pass++;
        tick();
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A || count !== 5'd1)
            $display("FAIL single_e2: got m_valid=%b m_data=%02h count=%0d expected 1 5a 1", m_valid, m_data, count); else n_pass++;
        tick();
        n_checks++;
        if (!popd) $display("FAIL single_pop: got no beat expected 5a");
        else if (q.size() == 0) $display("FAIL single_pop: got %02h expected none", pdata);
        else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL single_pop: got %02h expected %02h", pdata, exp_d); else n_pass++; end
        n_checks++; if (count !== 5'd0) $display("FAIL single_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_fill();
        int nxt;
        do_reset();
        nxt = 0;
        for (int t = 0; t < 16; t++) begin
            s_valid = 1'b1; s_data = nxt[7:0];
            tick();
            if (acc) nxt++;
        end
        n_checks++; if (nxt !== 10) $display("FAIL fill_accepted: got %0d expected 10", nxt); else n_pass++;
        n_checks++; if (s_ready !== 1'b0 || count !== 5'd10)
            $display("FAIL fill_full: got s_ready=%b count=%0d expected 0 10", s_ready, count); else n_pass++;
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h00)
            $display("FAIL fill_head: got m_valid=%b m_data=%02h expected 1 00", m_valid, m_data); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_checks++;
            if (!popd) $display("FAIL fill_drain_gap: got no beat at cycle %0d expected beat", t);
            else if (q.size() == 0) $display("FAIL fill_drain: got %02h expected none", pdata);
            else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL fill_drain: got %02h expected %02h", pdata, exp_d); else n_pass++; end
        end
        n_checks++; if (count !== 5'd0 || s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL fill_empty: got count=%0d s_ready=%b m_valid=%b expected 0 1 0", count, s_ready, m_valid); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_stream_wrap();
        int nxt;
        do_reset();
        nxt = 0;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            s_data = nxt[7:0];
            tick();
            if (acc) nxt++;
            n_checks++;
            if (popd !== (t >= 3)) $display("FAIL stream_rate: got pop=%b at cycle %0d expected %b", popd, t, (t >= 3));
            else if (!popd) n_pass++;
            else if (q.size() == 0) $display("FAIL stream_data: got %02h expected none", pdata);
            else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL stream_data: got %02h expected %02h", pdata, exp_d); else n_pass++; end
        end
        n_checks++; if (nxt !== 40) $display("FAIL stream_accepted: got %0d expected 40", nxt); else n_pass++;
        n_checks++; if (ram_a_addr !== 3'd0 || ram_b_addr !== 3'd7)
            $display("FAIL stream_wrap_ptr: got wr=%0d rd=%0d expected 0 7", ram_a_addr, ram_b_addr); else n_pass++;
        s_valid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (popd) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL stream_tail: got %02h expected none", pdata);
                else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL stream_tail: got %02h expected %02h", pdata, exp_d); else n_pass++; end
            end
        end
        n_checks++; if (count !== 5'd0 || q.size() != 0)
            $display("FAIL stream_empty: got count=%0d left=%0d expected 0 0", count, q.size()); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   n_push, n_pop, n_bad;
        logic hold, prev_stall;
        logic [7:0] prev_md;
        do_reset();
        n_push = 0; n_pop = 0; n_bad = 0; hold = 1'b0; prev_stall = 1'b0; prev_md = 8'h00;
        for (int cyc = 0; cyc < 20000 && n_pop < 1000; cyc++) begin
            if (!hold) begin
                s_valid = (n_push < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                s_data  = 8'($urandom);
            end
            m_ready = 1'($urandom_range(0, 1));
            tick();
            if (acc) n_push++;
            hold = s_valid && !acc;
            if (we_bad) n_bad++;
            if (prev_stall) begin
                n_checks++;
                if (mv !== 1'b1 || pdata !== prev_md)
                    $display("FAIL bp_stable: got m_valid=%b m_data=%02h expected 1 %02h", mv, pdata, prev_md);
                else n_pass++;
            end
            prev_stall = mv && !mr;
            prev_md    = pdata;
            if (popd) begin
                n_pop++;
                n_checks++;
                if (q.size() == 0) $display("FAIL bp_data: got %02h expected none", pdata);
                else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL bp_data: got %02h expected %02h", pdata, exp_d); else n_pass++; end
            end
            n_checks++;
            if (count !== 5'(q.size())) $display("FAIL bp_count: got %0d expected %0d", count, q.size()); else n_pass++;
        end
        n_checks++; if (n_pop !== 1000) $display("FAIL bp_done: got %0d beats expected 1000", n_pop); else n_pass++;
        n_checks++; if (n_bad !== 0) $display("FAIL bp_push_when_full: got %0d expected 0", n_bad); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            s_valid = 1'b1; s_data = 8'(8'h30 + t);
            tick();
        end
        s_valid = 1'b0;
        tick();
        n_checks++; if (count !== 5'd6) $display("FAIL mid_held: got %0d expected 6", count); else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++; if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00 || s_ready !== 1'b1)
            $display("FAIL mid_async: got count=%0d m_valid=%b m_data=%02h s_ready=%b expected 0 0 00 1", count, m_valid, m_data, s_ready); else n_pass++;
        n_checks++; if (ram_a_addr !== 3'd0 || ram_b_addr !== 3'd0)
            $display("FAIL mid_ptr: got a=%0d b=%0d expected 0 0", ram_a_addr, ram_b_addr); else n_pass++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        q.delete();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick();
            if (popd) begin
                found = 1'b1;
                n_checks++;
                if (q.size() == 0) $display("FAIL mid_first: got %02h expected none", pdata);
                else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL mid_first: got %02h expected %02h", pdata, exp_d); else n_pass++; end
            end
        end
        n_checks++; if (found !== 1'b1) $display("FAIL mid_timeout: got no beat expected a5"); else n_pass++;
        m_ready = 1'b0;
    endtask

`ifdef CHAN_FIFO_AFULL_EN
    task automatic test_afull();
        do_reset();
        for (int t = 0; t < 12; t++) begin
            s_valid = 1'b1; s_data = 8'(t);
            tick();
            n_checks++;
            if (s_afull !== (q.size() >= 8)) $display("FAIL afull_rise: got %b at depth %0d expected %b", s_afull, q.size(), (q.size() >= 8));
            else n_pass++;
        end
        s_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            if (popd) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL afull_data: got %02h expected none", pdata);
                else begin exp_d = q.pop_front(); if (pdata !== exp_d) $display("FAIL afull_data: got %02h expected %02h", pdata, exp_d); else n_pass++; end
            end
            n_checks++;
            if (s_afull !== (q.size() >= 8) || count !== 5'(q.size()))
                $display("FAIL afull_fall: got afull=%b count=%0d expected %b %0d", s_afull, count, (q.size() >= 8), q.size());
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_stream_wrap();
        test_backpressure();
        test_reset_mid();
`ifdef CHAN_FIFO_AFULL_EN
        test_afull();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
